// File: rtl/pic_rom_pkg.sv
// Shared types and widths for the picture ROM arbiter.
// Owner encoding is registered at issue and steers the one-cycle-late ROM data.
package pic_rom_pkg;

    localparam int ROM_AW = 14;
    localparam int ROM_DW = 2;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        DISP = 2'd1,
        C0   = 2'd2,
        C1   = 2'd3
    } owner_t;

endpackage

// File: rtl/pic_rom_arbiter_if.sv
// Bundle of display, client and ROM-side signals around the picture ROM arbiter.
// The slave modport is the arbiter; the master modport is the surrounding logic and ROM.
interface pic_rom_arbiter_if;
    import pic_rom_pkg::*;

    logic              disp_rd_en;
    logic [ROM_AW-1:0] disp_addr;
    logic [ROM_DW-1:0] disp_data;

    logic              c0_req;
    logic [ROM_AW-1:0] c0_addr;
    logic              c0_ack;
    logic              c0_valid;
    logic [ROM_DW-1:0] c0_data;

    logic              c1_req;
    logic [ROM_AW-1:0] c1_addr;
    logic              c1_ack;
    logic              c1_valid;
    logic [ROM_DW-1:0] c1_data;

    logic [ROM_AW-1:0] rom_addr;
    logic              rom_rden;
    logic [ROM_DW-1:0] rom_data;

    logic [1:0]        starve;

    modport slave (
        input  disp_rd_en, disp_addr, c0_req, c0_addr, c1_req, c1_addr, rom_data,
        output disp_data, c0_ack, c0_valid, c0_data, c1_ack, c1_valid, c1_data,
        output rom_addr, rom_rden, starve
    );

    modport master (
        output disp_rd_en, disp_addr, c0_req, c0_addr, c1_req, c1_addr, rom_data,
        input  disp_data, c0_ack, c0_valid, c0_data, c1_ack, c1_valid, c1_data,
        input  rom_addr, rom_rden, starve
    );

endinterface

// File: rtl/pic_rom_wait_mon.sv
// Per-client wait counter with a sticky starvation flag.
// Counts cycles with req high and no ack; the flag sets when the count reaches MAX_WAIT.
module pic_rom_wait_mon #(
    parameter int WAIT_W   = 10,
    parameter int MAX_WAIT = 800
) (
    input  logic vga_clk,
    input  logic sys_rst_n,
    input  logic req,
    input  logic ack,
    output logic starve
);

    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (req && !ack) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q  <= '0;
            starve <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (cnt_d == MAX_CNT) begin
                starve <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pic_rom_arbiter.sv
// Picture ROM arbiter: display fetch has absolute priority, two clients share idle cycles
// round-robin; ROM data is steered back one cycle later by the registered owner.
module pic_rom_arbiter
    import pic_rom_pkg::*;
#(
    parameter int WAIT_W   = 10,
    parameter int MAX_WAIT = 800
) (
    input  logic             vga_clk,
    input  logic             sys_rst_n,
    pic_rom_arbiter_if.slave bus
);

    owner_t            owner_q;
    owner_t            owner_d;
    logic              rr_last;
    logic [ROM_AW-1:0] addr_q;
    logic [ROM_AW-1:0] addr_d;
    logic              gnt_disp;
    logic              gnt_c0;
    logic              gnt_c1;
    logic              starve0;
    logic              starve1;

    // Grants are gated by reset so no ack or ROM read can escape while reset is held.
    always_comb begin
        gnt_disp = sys_rst_n & bus.disp_rd_en;
        gnt_c0   = sys_rst_n & ~bus.disp_rd_en & bus.c0_req & (~bus.c1_req | rr_last);
        gnt_c1   = sys_rst_n & ~bus.disp_rd_en & bus.c1_req & (~bus.c0_req | ~rr_last);

        owner_d = NONE;
        addr_d  = addr_q;
        if (gnt_disp) begin
            owner_d = DISP;
            addr_d  = bus.disp_addr;
        end else if (gnt_c0) begin
            owner_d = C0;
            addr_d  = bus.c0_addr;
        end else if (gnt_c1) begin
            owner_d = C1;
            addr_d  = bus.c1_addr;
        end
    end

    assign bus.rom_rden = gnt_disp | gnt_c0 | gnt_c1;
    assign bus.rom_addr = addr_d;
    assign bus.c0_ack   = gnt_c0;
    assign bus.c1_ack   = gnt_c1;

    // rr_last = 1 means client 1 was served last, so client 0 wins the next tie.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            owner_q <= NONE;
            rr_last <= 1'b1;
            addr_q  <= '0;
        end else begin
            owner_q <= owner_d;
            addr_q  <= addr_d;
            if (gnt_c0) begin
                rr_last <= 1'b0;
            end else if (gnt_c1) begin
                rr_last <= 1'b1;
            end
        end
    end

    // Return stage: ROM output belongs to whoever issued in the previous cycle.
    assign bus.disp_data = (owner_q == DISP) ? bus.rom_data : '0;
    assign bus.c0_valid  = (owner_q == C0);
    assign bus.c0_data   = (owner_q == C0) ? bus.rom_data : '0;
    assign bus.c1_valid  = (owner_q == C1);
    assign bus.c1_data   = (owner_q == C1) ? bus.rom_data : '0;

    pic_rom_wait_mon #(
        .WAIT_W   (WAIT_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_c0 (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .req       (bus.c0_req),
        .ack       (gnt_c0),
        .starve    (starve0)
    );

    pic_rom_wait_mon #(
        .WAIT_W   (WAIT_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_c1 (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .req       (bus.c1_req),
        .ack       (gnt_c1),
        .starve    (starve1)
    );

    assign bus.starve = {starve1, starve0};

endmodule

// File: tb/tb_pic_rom_arbiter.sv
// Directed bench for pic_rom_arbiter with a small registered ROM model.
// Expected ROM contents below are hand-computed from rom_f.
module tb_pic_rom_arbiter;
    import pic_rom_pkg::*;

    logic vga_clk = 1'b0;
    logic sys_rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    pic_rom_arbiter_if bus ();

    pic_rom_arbiter #(.WAIT_W(10), .MAX_WAIT(800)) dut (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 vga_clk = ~vga_clk;

    // ROM content: low two bits of the XOR of the address nibbles.
    function automatic logic [ROM_DW-1:0] rom_f(input logic [ROM_AW-1:0] a);
        logic [ROM_AW-1:0] t;
        t = a ^ (a >> 4) ^ (a >> 8) ^ (a >> 12);
        return t[ROM_DW-1:0];
    endfunction

    always @(posedge vga_clk) begin
        if (bus.rom_rden) bus.rom_data <= rom_f(bus.rom_addr);
    end

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.disp_rd_en = 1'b0; bus.disp_addr = '0;
        bus.c0_req = 1'b0; bus.c0_addr = '0;
        bus.c1_req = 1'b0; bus.c1_addr = '0;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        sys_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        idle_inputs();
        bus.c0_req = 1'b1;
        #3;
        n_tests++; if (bus.c0_ack !== 1'b0) begin n_fail++; $display("FAIL reset_c0_ack got %0b want 0", bus.c0_ack); end
        tick();
        n_tests++; if (bus.rom_rden !== 1'b0) begin n_fail++; $display("FAIL reset_rom_rden got %0b want 0", bus.rom_rden); end
        n_tests++; if (bus.rom_addr !== 14'd0) begin n_fail++; $display("FAIL reset_rom_addr got %h want 0", bus.rom_addr); end
        n_tests++; if ({bus.c0_valid, bus.c1_valid, bus.c1_ack} !== 3'b000) begin n_fail++; $display("FAIL reset_valid_ack got %b want 000", {bus.c0_valid, bus.c1_valid, bus.c1_ack}); end
        n_tests++; if ({bus.disp_data, bus.c0_data, bus.c1_data} !== 6'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", {bus.disp_data, bus.c0_data, bus.c1_data}); end
        n_tests++; if (bus.starve !== 2'b00) begin n_fail++; $display("FAIL reset_starve got %b want 00", bus.starve); end
        do_reset();
    endtask

    task automatic test_disp_priority();
        logic [1:0] dexp [4] = '{2'd1, 2'd0, 2'd3, 2'd2};
        bus.disp_rd_en = 1'b1; bus.disp_addr = 14'h0010;
        bus.c0_req = 1'b1; bus.c0_addr = 14'h2000;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (bus.c0_ack !== 1'b0) begin n_fail++; $display("FAIL prio_c0_ack cyc %0d got %0b want 0", i, bus.c0_ack); end
            n_tests++; if (bus.rom_addr !== 14'(16 + i)) begin n_fail++; $display("FAIL prio_rom_addr cyc %0d got %h want %h", i, bus.rom_addr, 16 + i); end
            tick();
            n_tests++; if (bus.disp_data !== dexp[i]) begin n_fail++; $display("FAIL prio_disp_data cyc %0d got %0d want %0d", i, bus.disp_data, dexp[i]); end
            n_tests++; if (bus.c0_valid !== 1'b0) begin n_fail++; $display("FAIL prio_c0_valid cyc %0d got %0b want 0", i, bus.c0_valid); end
            if (i < 3) bus.disp_addr = 14'(17 + i);
            else       bus.disp_rd_en = 1'b0;
            #1;
        end
        n_tests++; if (bus.c0_ack !== 1'b1) begin n_fail++; $display("FAIL prio_c0_ack_late got %0b want 1", bus.c0_ack); end
        n_tests++; if (bus.rom_addr !== 14'h2000) begin n_fail++; $display("FAIL prio_c0_addr got %h want 2000", bus.rom_addr); end
        tick();
        n_tests++; if (bus.c0_valid !== 1'b1) begin n_fail++; $display("FAIL prio_c0_valid_ret got %0b want 1", bus.c0_valid); end
        n_tests++; if (bus.c0_data !== 2'd2) begin n_fail++; $display("FAIL prio_c0_data got %0d want 2", bus.c0_data); end
        n_tests++; if (bus.disp_data !== 2'd0) begin n_fail++; $display("FAIL prio_disp_data_idle got %0d want 0", bus.disp_data); end
        bus.c0_req = 1'b0;
        #1;
        n_tests++; if (bus.c0_ack !== 1'b0) begin n_fail++; $display("FAIL prio_c0_ack_drop got %0b want 0", bus.c0_ack); end
        tick();
        n_tests++; if (bus.c0_valid !== 1'b0) begin n_fail++; $display("FAIL prio_c0_valid_end got %0b want 0", bus.c0_valid); end
    endtask

    task automatic test_round_robin();
        logic w0;
        do_reset();
        bus.c0_req = 1'b1; bus.c0_addr = 14'h0100;
        bus.c1_req = 1'b1; bus.c1_addr = 14'h0200;
        #1;
        for (int k = 0; k < 6; k++) begin
            w0 = (k % 2 == 0);
            n_tests++; if ({bus.c0_ack, bus.c1_ack} !== {w0, ~w0}) begin n_fail++; $display("FAIL rr_ack cyc %0d got %b want %b", k, {bus.c0_ack, bus.c1_ack}, {w0, ~w0}); end
            tick();
            n_tests++; if ({bus.c0_valid, bus.c1_valid} !== {w0, ~w0}) begin n_fail++; $display("FAIL rr_valid cyc %0d got %b want %b", k, {bus.c0_valid, bus.c1_valid}, {w0, ~w0}); end
            n_tests++; if ({bus.c0_data, bus.c1_data} !== (w0 ? 4'b0100 : 4'b0010)) begin n_fail++; $display("FAIL rr_data cyc %0d got %b want %b", k, {bus.c0_data, bus.c1_data}, (w0 ? 4'b0100 : 4'b0010)); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_starve();
        do_reset();
        bus.disp_rd_en = 1'b1; bus.disp_addr = 14'h0000;
        bus.c1_req = 1'b1; bus.c1_addr = 14'h0030;
        for (int i = 1; i <= 800; i++) begin
            tick();
            if (i == 400) begin
                n_tests++; if (bus.c1_ack !== 1'b0) begin n_fail++; $display("FAIL starve_c1_ack got %0b want 0", bus.c1_ack); end
            end
            if (i == 799) begin
                n_tests++; if (bus.starve !== 2'b00) begin n_fail++; $display("FAIL starve_early got %b want 00", bus.starve); end
            end
            if (i == 800) begin
                n_tests++; if (bus.starve !== 2'b10) begin n_fail++; $display("FAIL starve_set got %b want 10", bus.starve); end
            end
        end
        idle_inputs();
        tick();
        tick();
        n_tests++; if (bus.starve !== 2'b10) begin n_fail++; $display("FAIL starve_sticky got %b want 10", bus.starve); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] cexp [3] = '{2'd1, 2'd2, 2'd3};
        bus.c0_req = 1'b1; bus.c0_addr = 14'h0005;
        #1;
        n_tests++; if (bus.c0_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack cyc 0 got %0b want 1", bus.c0_ack); end
        for (int j = 0; j < 3; j++) begin
            tick();
            n_tests++; if (bus.c0_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid cyc %0d got %0b want 1", j, bus.c0_valid); end
            n_tests++; if (bus.c0_data !== cexp[j]) begin n_fail++; $display("FAIL b2b_data cyc %0d got %0d want %0d", j, bus.c0_data, cexp[j]); end
            if (j < 2) bus.c0_addr = 14'(6 + j);
            else       bus.c0_req = 1'b0;
            #1;
            n_tests++; if (bus.c0_ack !== (j < 2)) begin n_fail++; $display("FAIL b2b_ack cyc %0d got %0b want %0b", j + 1, bus.c0_ack, (j < 2)); end
        end
        tick();
        n_tests++; if (bus.c0_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_end got %0b want 0", bus.c0_valid); end
    endtask

    task automatic test_reset_mid_read();
        bus.c0_req = 1'b1; bus.c0_addr = 14'h0005;
        #1;
        n_tests++; if (bus.c0_ack !== 1'b1) begin n_fail++; $display("FAIL rmid_ack got %0b want 1", bus.c0_ack); end
        #1;
        sys_rst_n = 1'b0;
        bus.c0_req = 1'b0;
        #1;
        n_tests++; if ({bus.c0_valid, bus.c0_ack} !== 2'b00) begin n_fail++; $display("FAIL rmid_in_reset got %b want 00", {bus.c0_valid, bus.c0_ack}); end
        tick();
        n_tests++; if (bus.c0_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %0b want 0", bus.c0_valid); end
        n_tests++; if ({bus.rom_rden, bus.rom_addr} !== 15'd0) begin n_fail++; $display("FAIL rmid_rom got %h want 0", {bus.rom_rden, bus.rom_addr}); end
        n_tests++; if ({bus.disp_data, bus.c0_data, bus.c1_data, bus.starve} !== 8'd0) begin n_fail++; $display("FAIL rmid_outs got %h want 0", {bus.disp_data, bus.c0_data, bus.c1_data, bus.starve}); end
        tick();
        sys_rst_n = 1'b1;
        n_tests++; if (bus.c0_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid_release got %0b want 0", bus.c0_valid); end
        bus.c0_req = 1'b1; bus.c0_addr = 14'h0100;
        bus.c1_req = 1'b1; bus.c1_addr = 14'h0200;
        #1;
        n_tests++; if ({bus.c0_ack, bus.c1_ack} !== 2'b10) begin n_fail++; $display("FAIL rmid_first_tie got %b want 10", {bus.c0_ack, bus.c1_ack}); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_disp_alone();
        logic        en   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [13:0] aexp [5] = '{14'h21, 14'h21, 14'h23, 14'h24, 14'h24};
        logic [1:0]  dexp [5] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd0};
        for (int i = 0; i < 5; i++) begin
            bus.disp_rd_en = en[i];
            bus.disp_addr  = 14'(33 + i);
            #1;
            n_tests++; if (bus.rom_rden !== en[i]) begin n_fail++; $display("FAIL alone_rden cyc %0d got %0b want %0b", i, bus.rom_rden, en[i]); end
            n_tests++; if (bus.rom_addr !== aexp[i]) begin n_fail++; $display("FAIL alone_addr cyc %0d got %h want %h", i, bus.rom_addr, aexp[i]); end
            tick();
            n_tests++; if (bus.disp_data !== dexp[i]) begin n_fail++; $display("FAIL alone_disp_data cyc %0d got %0d want %0d", i, bus.disp_data, dexp[i]); end
            n_tests++; if ({bus.c0_ack, bus.c1_ack, bus.c0_valid, bus.c1_valid, bus.c0_data, bus.c1_data} !== 8'd0) begin n_fail++; $display("FAIL alone_clients cyc %0d got %h want 0", i, {bus.c0_ack, bus.c1_ack, bus.c0_valid, bus.c1_valid, bus.c0_data, bus.c1_data}); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_disp_priority();
        test_round_robin();
        test_starve();
        test_back_to_back();
        test_reset_mid_read();
        test_disp_alone();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
